// File: rtl/multiply_pkg.sv
// multiply_pkg: default widths and derived constants for the multiply block
package multiply_pkg;
  localparam int MUL_WIDTH_A = 10;
  localparam int MUL_WIDTH_B = 10;
  localparam int MUL_HALF_B = MUL_WIDTH_B / 2;
  localparam int MUL_OUT_W = MUL_WIDTH_A + MUL_WIDTH_B;
endpackage

// File: rtl/multiply_half.sv
// multiply_half: combinational WIDTH_A x WIDTH_H unsigned multiplier from AND rows and an adder tree
module multiply_half import multiply_pkg::*; #(
  parameter int WIDTH_A = MUL_WIDTH_A,
  parameter int WIDTH_H = MUL_HALF_B
) (
  input  logic [WIDTH_A-1:0]         A,
  input  logic [WIDTH_H-1:0]         B,
  output logic [WIDTH_A+WIDTH_H-1:0] out
);
  localparam int W = WIDTH_A + WIDTH_H;
  // heap-ordered tree: leaves at WIDTH_H-1.., node k sums children 2k+1 and 2k+2
  logic [W-1:0] node [2*WIDTH_H-1];
  for (genvar i = 0; i < WIDTH_H; i++) begin : g_row
    assign node[WIDTH_H-1+i] = (W'(A) << i) & {W{B[i]}};
  end
  for (genvar k = 0; k < WIDTH_H-1; k++) begin : g_sum
    assign node[k] = node[2*k+1] + node[2*k+2];
  end
  assign out = node[0];
endmodule

// File: rtl/multiply.sv
// multiply: two-stage pipelined unsigned WIDTH_A x WIDTH_B multiplier
module multiply import multiply_pkg::*; #(
  parameter int WIDTH_A = MUL_WIDTH_A,
  parameter int WIDTH_B = MUL_WIDTH_B
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_A-1:0]         A,
  input  logic [WIDTH_B-1:0]         B,
  output logic [WIDTH_A+WIDTH_B-1:0] out
);
  localparam int H = WIDTH_B / 2;
  localparam int W = WIDTH_A + H;
  localparam int OW = WIDTH_A + WIDTH_B;
  logic [W-1:0] lo_c, hi_c, p_lo, p_hi;
  multiply_half #(.WIDTH_A(WIDTH_A), .WIDTH_H(H)) u_lo (.A(A), .B(B[H-1:0]), .out(lo_c));
  multiply_half #(.WIDTH_A(WIDTH_A), .WIDTH_H(H)) u_hi (.A(A), .B(B[WIDTH_B-1:H]), .out(hi_c));
  always_ff @(posedge clk) begin
    if (rst) begin
      p_lo <= '0;
      p_hi <= '0;
      out  <= '0;
    end else begin
      p_lo <= lo_c;
      p_hi <= hi_c;
      out  <= OW'(p_lo) + (OW'(p_hi) << H);
    end
  end
endmodule

// File: tb/tb_multiply.sv
// tb_multiply: directed table, streaming, reset-flush and sweep checks for multiply
module tb_multiply;
  logic clk = 0;
  logic rst = 1;
  logic [9:0] A = 0;
  logic [9:0] B = 0;
  logic [19:0] out;
  int asserts = 0;
  int fails = 0;
  logic [19:0] prev = 0;
  bit have_prev = 0;
  string prev_name = "";

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic [19:0] p;
    string       name;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  multiply dut (.clk(clk), .rst(rst), .A(A), .B(B), .out(out));

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: out=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [9:0] a, input logic [9:0] b, input logic [19:0] p, input string name);
    @(negedge clk);
    A = a;
    B = b;
    rst = 0;
    @(posedge clk);
    #1;
    if (have_prev) check(prev_name, out, prev);
    prev = p;
    prev_name = name;
    have_prev = 1;
  endtask

  task automatic drain;
    @(negedge clk);
    @(posedge clk);
    #1;
    if (have_prev) check(prev_name, out, prev);
    have_prev = 0;
  endtask

  initial begin
    vecs[0]  = '{10'd10,   10'd10,   20'd100,     "basic_10x10"};
    vecs[1]  = '{10'd3,    10'd2,    20'd6,       "basic_3x2"};
    vecs[2]  = '{10'd1023, 10'd1023, 20'hFF801,   "max_x_max"};
    vecs[3]  = '{10'd1023, 10'd0,    20'd0,       "max_x_0"};
    vecs[4]  = '{10'd0,    10'd1023, 20'd0,       "0_x_max"};
    vecs[5]  = '{10'd1,    10'd1,    20'd1,       "1_x_1"};
    vecs[6]  = '{10'd1023, 10'd32,   20'd32736,   "half_boundary_32"};
    vecs[7]  = '{10'd1023, 10'd31,   20'd31713,   "low_half_full_31"};
    vecs[8]  = '{10'd512,  10'd512,  20'd262144,  "512_x_512"};
    vecs[9]  = '{10'd5,    10'd1000, 20'd5000,    "5_x_1000"};
    vecs[10] = '{10'd700,  10'd3,    20'd2100,    "700_x_3"};

    A = 10'd1023;
    B = 10'd1023;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 20'd0);

    // first edge after release only samples, so out must still read 0
    have_prev = 1;
    prev = 0;
    prev_name = "post_reset_first_edge";
    for (int i = 0; i < 11; i++) push(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
    drain();

    for (int i = 0; i < 100; i++) begin
      logic [9:0] a, b;
      a = 10'($urandom);
      b = 10'($urandom);
      push(a, b, 20'(a) * 20'(b), "stream_random");
    end
    drain();

    push(10'd77, 10'd99, 20'd7623, "pre_reset_p0");
    push(10'd600, 10'd900, 20'd540000, "pre_reset_p1");
    have_prev = 0;
    @(negedge clk);
    A = 10'd1000;
    B = 10'd1000;
    rst = 1;
    @(posedge clk);
    #1;
    check("reset_midstream_out", out, 20'd0);
    have_prev = 1;
    prev = 0;
    prev_name = "reset_flush_inflight";
    push(10'd17, 10'd19, 20'd323, "post_reset_p3");
    push(10'd1023, 10'd512, 20'd523776, "post_reset_p4");
    push(10'd256, 10'd4, 20'd1024, "post_reset_p5");
    drain();

    for (int a = 0; a < 1024; a++) begin
      logic [9:0] av, bv;
      av = 10'(a);
      bv = 10'((a * 613 + 17) % 1024);
      push(av, bv, 20'(av) * 20'(bv), "sweep");
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
